// File: rtl/seq_gen.sv
// seq_gen: bursts of a fixed 6-bit serial frame (MSB first), repeated
// repeat_cnt times with GAP idle cycles between frames.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start with a non-zero repeat_cnt
// SEND   | shifting out PATTERN[bit_idx], bit_idx counting 5 down to 0
// GAP    | idle cycles between frames, gap_cnt counting down to 0
// DONE   | one-cycle completion pulse, then back to IDLE
//
// Every output is a flop computed from the next-state values, so the
// outputs always describe the state the FSM is in during that cycle.
module seq_gen #(
   parameter logic [5:0]  PATTERN = 6'b101101,
   parameter int unsigned GAP     = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] repeat_cnt,
   input  logic       abort,
   output logic       data_out,
   output logic       data_valid,
   output logic       busy,
   output logic       done,
   output logic [3:0] frame_idx
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_GAP  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // gap counter loads GAP-1 and runs to 0, giving exactly GAP cycles
   localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

   state_t     state_q, state_d;
   logic [2:0] bit_q, bit_d;
   logic [3:0] frame_q, frame_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] gap_q, gap_d;
   logic       data_out_q, data_out_d;
   logic       data_valid_q, data_valid_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;

   // next-state, counters and registered-output values
   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      frame_d = frame_q;
      cnt_d   = cnt_q;
      gap_d   = gap_q;
      case (state_q)
         S_IDLE: begin
            if (start && !abort && (repeat_cnt != 4'd0)) begin
               state_d = S_SEND;
               bit_d   = 3'd5;
               frame_d = 4'd0;
               cnt_d   = repeat_cnt;
            end
         end
         S_SEND: begin
            if (abort) begin
               state_d = S_IDLE;
               bit_d   = 3'd5;
               frame_d = 4'd0;
            end else if (bit_q == 3'd0) begin
               bit_d = 3'd5;
               if (frame_q == cnt_q - 4'd1) begin
                  state_d = S_DONE;
                  frame_d = 4'd0;
               end else if (GAP != 0) begin
                  state_d = S_GAP;
                  gap_d   = GAP_LAST;
               end else begin
                  frame_d = frame_q + 4'd1;
               end
            end else begin
               bit_d = bit_q - 3'd1;
            end
         end
         S_GAP: begin
            if (abort) begin
               state_d = S_IDLE;
               bit_d   = 3'd5;
               frame_d = 4'd0;
            end else if (gap_q == 4'd0) begin
               state_d = S_SEND;
               bit_d   = 3'd5;
               frame_d = frame_q + 4'd1;
            end else begin
               gap_d = gap_q - 4'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            frame_d = 4'd0;
         end
         default: begin
            state_d = S_IDLE;
            bit_d   = 3'd5;
            frame_d = 4'd0;
         end
      endcase

      data_valid_d = (state_d == S_SEND);
      data_out_d   = data_valid_d & PATTERN[bit_d];
      busy_d       = (state_d == S_SEND) || (state_d == S_GAP);
      done_d       = (state_d == S_DONE);
   end

   // state and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         bit_q        <= 3'd5;
         frame_q      <= 4'd0;
         cnt_q        <= 4'd0;
         gap_q        <= 4'd0;
         data_out_q   <= 1'b0;
         data_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_q        <= bit_d;
         frame_q      <= frame_d;
         cnt_q        <= cnt_d;
         gap_q        <= gap_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign frame_idx  = frame_q;

endmodule

// File: tb/tb_seq_gen.sv
// Testbench for seq_gen: a default instance (GAP=2) and a GAP=0 instance
// share the stimulus; vector table plus hand-written corner sequences.
module tb_seq_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] repeat_cnt = 4'd0;
   logic       abort = 1'b0;

   logic       d_out, d_valid, d_busy, d_done;
   logic [3:0] d_frame;
   logic       z_out, z_valid, z_busy, z_done;
   logic [3:0] z_frame;

   int checks = 0;
   int errors = 0;

   localparam logic [5:0] EXP_PAT = 6'b101101;

   always #5 clk = ~clk;

   seq_gen dut (
      .clk(clk), .rst(rst), .start(start), .repeat_cnt(repeat_cnt), .abort(abort),
      .data_out(d_out), .data_valid(d_valid), .busy(d_busy), .done(d_done),
      .frame_idx(d_frame)
   );

   seq_gen #(.PATTERN(6'b101101), .GAP(0)) dut0 (
      .clk(clk), .rst(rst), .start(start), .repeat_cnt(repeat_cnt), .abort(abort),
      .data_out(z_out), .data_valid(z_valid), .busy(z_busy), .done(z_done),
      .frame_idx(z_frame)
   );

   typedef struct {
      logic       st;
      logic [3:0] rc;
      logic       ab;
      logic       e_out;
      logic       e_valid;
      logic       e_busy;
      logic       e_done;
      logic [3:0] e_frame;
   } vec_t;

   vec_t vecs[40];
   int   nvec = 0;

   task automatic add(input logic st, input logic [3:0] rc, input logic ab,
                      input logic o, input logic v, input logic b,
                      input logic d, input logic [3:0] f);
      vecs[nvec].st      = st;
      vecs[nvec].rc      = rc;
      vecs[nvec].ab      = ab;
      vecs[nvec].e_out   = o;
      vecs[nvec].e_valid = v;
      vecs[nvec].e_busy  = b;
      vecs[nvec].e_done  = d;
      vecs[nvec].e_frame = f;
      nvec++;
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // advance one clock; outputs are then sampled 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      start = 1'b0;
      abort = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin : main
      logic [5:0] sh;
      int         nbits;
      int         hits;
      int         seen_done;

      // ---- table: single frame, then 2 frames with GAP=2 and ignored start
      add(1, 4'd1, 0, 1, 1, 1, 0, 0);
      for (int i = 4; i >= 0; i--) add(0, 4'd0, 0, EXP_PAT[i], 1, 1, 0, 0);
      add(0, 4'd0, 0, 0, 0, 0, 1, 0);
      add(0, 4'd0, 0, 0, 0, 0, 0, 0);

      add(1, 4'd2, 0, 1, 1, 1, 0, 0);
      for (int i = 4; i >= 0; i--)
         add((i == 2), 4'd7, 0, EXP_PAT[i], 1, 1, 0, 0);
      add(0, 4'd0, 0, 0, 0, 1, 0, 0);
      add(1, 4'd5, 0, 0, 0, 1, 0, 0);
      for (int i = 5; i >= 0; i--) add(0, 4'd0, 0, EXP_PAT[i], 1, 1, 0, 1);
      add(1, 4'd3, 0, 0, 0, 0, 1, 0);
      add(0, 4'd0, 0, 0, 0, 0, 0, 0);

      // ---- reset state
      step();
      step();
      chk("rst_data_out", d_out, 0);
      chk("rst_valid", d_valid, 0);
      chk("rst_busy", d_busy, 0);
      chk("rst_done", d_done, 0);
      chk("rst_frame", d_frame, 0);
      rst = 1'b0;
      idle(2);

      // ---- table-driven vectors
      for (int k = 0; k < nvec; k++) begin
         start      = vecs[k].st;
         repeat_cnt = vecs[k].rc;
         abort      = vecs[k].ab;
         step();
         chk($sformatf("vec%0d_out", k), d_out, vecs[k].e_out);
         chk($sformatf("vec%0d_valid", k), d_valid, vecs[k].e_valid);
         chk($sformatf("vec%0d_busy", k), d_busy, vecs[k].e_busy);
         chk($sformatf("vec%0d_done", k), d_done, vecs[k].e_done);
         chk($sformatf("vec%0d_frame", k), d_frame, vecs[k].e_frame);
      end
      idle(30);

      // ---- GAP=0, 3 frames back to back, paired 101101 detector
      start = 1'b1;
      repeat_cnt = 4'd3;
      step();
      start = 1'b0;
      sh = 6'd0;
      nbits = 0;
      hits = 0;
      for (int i = 0; i < 18; i++) begin
         chk($sformatf("g0_valid%0d", i), z_valid, 1);
         chk($sformatf("g0_bit%0d", i), z_out, EXP_PAT[5 - (i % 6)]);
         chk($sformatf("g0_frame%0d", i), z_frame, 8'(i / 6));
         chk($sformatf("g0_busy%0d", i), z_busy, 1);
         if (z_valid) begin
            sh = {sh[4:0], z_out};
            nbits++;
            if (nbits >= 6 && sh == 6'b101101) begin
               hits++;
               nbits = 0;
            end
         end
         step();
      end
      chk("g0_done", z_done, 1);
      chk("g0_done_busy", z_busy, 0);
      chk("g0_done_valid", z_valid, 0);
      chk("g0_detect_hits", 8'(hits), 3);
      idle(30);

      // ---- start with repeat_cnt=0 is ignored
      start = 1'b1;
      repeat_cnt = 4'd0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk($sformatf("rc0_busy%0d", i), d_busy, 0);
         chk($sformatf("rc0_valid%0d", i), d_valid, 0);
         chk($sformatf("rc0_done%0d", i), d_done, 0);
      end
      idle(3);

      // ---- abort on the third bit of frame 0
      start = 1'b1;
      repeat_cnt = 4'd2;
      step();
      start = 1'b0;
      step();
      step();
      chk("ab_third_bit", d_out, EXP_PAT[3]);
      chk("ab_third_valid", d_valid, 1);
      abort = 1'b1;
      start = 1'b1;
      step();
      abort = 1'b0;
      start = 1'b0;
      chk("ab_busy", d_busy, 0);
      chk("ab_valid", d_valid, 0);
      chk("ab_frame", d_frame, 0);
      seen_done = 0;
      for (int i = 0; i < 10; i++) begin
         if (d_done || d_busy) seen_done++;
         step();
      end
      chk("ab_no_done", 8'(seen_done), 0);
      start = 1'b1;
      repeat_cnt = 4'd1;
      for (int i = 5; i >= 0; i--) begin
         step();
         start = 1'b0;
         chk($sformatf("ab_restart_bit%0d", i), d_out, EXP_PAT[i]);
         chk($sformatf("ab_restart_valid%0d", i), d_valid, 1);
      end
      step();
      chk("ab_restart_done", d_done, 1);
      idle(30);

      // ---- reset during GAP (dut0 is mid-frame at the same time)
      start = 1'b1;
      repeat_cnt = 4'd2;
      step();
      start = 1'b0;
      for (int i = 0; i < 6; i++) step();
      chk("rg_in_gap_busy", d_busy, 1);
      chk("rg_in_gap_valid", d_valid, 0);
      rst = 1'b1;
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("rg_data_out", d_out, 0);
      chk("rg_valid", d_valid, 0);
      chk("rg_busy", d_busy, 0);
      chk("rg_done", d_done, 0);
      chk("rg_frame", d_frame, 0);
      chk("rg0_busy", z_busy, 0);
      chk("rg0_valid", z_valid, 0);
      start = 1'b1;
      repeat_cnt = 4'd1;
      step();
      chk("rg_start_in_rst", d_busy, 0);
      rst = 1'b0;
      start = 1'b0;
      step();
      chk("rg_after_rst_busy", d_busy, 0);
      chk("rg_after_rst_done", d_done, 0);
      idle(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 SHALL have parameter PATTERN, default 6'b101101, meaning the 6-bit frame transmitted MSB first.
REQ-002 SHALL have parameter GAP, default 2, meaning idle (zero, invalid) cycles inserted between consecutive frames; legal range 0..15.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  request to begin a burst, sampled only in IDLE.
REQ-006 SHALL have port repeat_cnt  input  4  number of frames in the burst, sampled with start.
REQ-007 SHALL have port abort  input  1  synchronous burst cancel.
REQ-008 SHALL have port data_out  output  1  serial pattern bit; 0 whenever data_valid=0.
REQ-009 SHALL have port data_valid  output  1  data_out carries a pattern bit this cycle.
REQ-010 SHALL have port busy  output  1  burst in progress (SEND or GAP state).
REQ-011 SHALL have port done  output  1  one-cycle pulse after the last bit of a completed burst.
REQ-012 SHALL have port frame_idx  output  4  0-based index of the frame being sent or gapped; 0 outside a burst.

Function
REQ-013 SHALL implement FSM states IDLE, SEND, GAP, DONE, with all outputs registered.
REQ-014 SHALL, in IDLE with start=1, abort=0 and repeat_cnt!=0, latch repeat_cnt, enter SEND next cycle with bit index 5 and frame_idx=0.
REQ-015 SHALL ignore start when repeat_cnt=0: stay IDLE, no busy, no done.
REQ-016 SHALL ignore start in SEND, GAP and DONE; the latched count does not change.
REQ-017 SHALL, in SEND, drive data_out=PATTERN[bit index], data_valid=1, and decrement bit index each cycle from 5 to 0.
REQ-018 SHALL, after bit 0 of a frame that is not the last: enter GAP if GAP>0, else go directly to SEND with bit index 5 (back-to-back frames, no bubble).
REQ-019 SHALL hold GAP for exactly GAP cycles with data_valid=0, data_out=0, busy=1, then enter SEND with bit index 5 and frame_idx incremented.
REQ-020 SHALL increment frame_idx on the first bit of each new frame, for both the gap and back-to-back paths.
REQ-021 SHALL, after bit 0 of the last frame (frame_idx = latched count - 1), enter DONE; no gap follows the last frame.
REQ-022 SHALL, in DONE, assert done=1, busy=0, data_valid=0 for exactly one cycle, then return to IDLE; start in DONE is ignored.
REQ-023 SHALL, on abort=1 in SEND or GAP, enter IDLE next cycle with data_valid=0, busy=0, frame_idx=0 and no done pulse; abort in IDLE or DONE has no effect, and abort has priority over start.
REQ-024 SHALL give a burst of N frames a duration of 6*N + GAP*(N-1) busy cycles, followed by 1 done cycle.
REQ-025 SHALL produce output that a non-overlapping 101101 detector on the same clock, gated by data_valid, flags exactly N times per burst with the default PATTERN.

Reset
REQ-026 SHALL, when rst=1 at a rising edge, enter IDLE with data_out=0, data_valid=0, busy=0, done=0, frame_idx=0, bit index 5 and latched count 0, regardless of state, including mid-frame.
REQ-027 SHALL give rst priority over abort and start; start with rst=1 is discarded.

Verification
REQ-028 SHALL check default params, start with repeat_cnt=1 at cycle T -> data_out 1,0,1,1,0,1 with data_valid=1 at T+1..T+6, done=1 at T+7, busy=0 at T+7.
REQ-029 SHALL check repeat_cnt=2, GAP=2 -> frame bits at T+1..T+6, data_valid=0 at T+7..T+8, bits at T+9..T+14 with frame_idx=1, done at T+15.
REQ-030 SHALL check GAP=0, repeat_cnt=3 -> 18 consecutive valid bits 101101101101101101, done at T+19, and the paired detector fires 3 times.
REQ-031 SHALL check repeat_cnt=0 with start -> busy, data_valid and done stay 0 for 10 cycles.
REQ-032 SHALL check abort at the 3rd bit of frame 0 -> next cycle busy=0, data_valid=0, and done never pulses; a new start then sends a full frame.
REQ-033 SHALL check rst=1 during GAP, and start asserted while busy -> all outputs 0 the cycle after reset; start while busy leaves burst length unchanged.
